// File: rtl/branch_predictor_pkg.sv
// -----------------------------------------------------------------------------
// branch_predictor_pkg
// Shared types for the fetch-side branch predictor:
//   op_type      - resolved instruction class delivered by the EX stage
//   btb_entry_t  - one BTB entry {valid, tag, target, ctr, is_jump}
//   CTR_WEAK_T / CTR_WEAK_NT - 2-bit counter encodings used for alloc/reset
//   is_ctrl_op() - true for instruction classes that redirect control flow
// -----------------------------------------------------------------------------
package branch_predictor_pkg;

  typedef enum logic [2:0] {
    OP_ALU    = 3'd0,
    OP_LOAD   = 3'd1,
    OP_STORE  = 3'd2,
    OP_BRANCH = 3'd3,
    OP_JAL    = 3'd4,
    OP_JALR   = 3'd5,
    OP_LUI    = 3'd6,
    OP_SYSTEM = 3'd7
  } op_type;

  // Widest tag any legal table size needs (ENTRIES >= 2 leaves at most 29 tag
  // bits). Smaller tables zero-extend into this field; the constant upper
  // bits are pruned by synthesis.
  localparam int TAG_MAX_W = 29;

  localparam logic [1:0] CTR_WEAK_T  = 2'b10;
  localparam logic [1:0] CTR_WEAK_NT = 2'b01;

  typedef struct packed {
    logic                 valid;
    logic [TAG_MAX_W-1:0] tag;
    logic [31:0]          target;
    logic [1:0]           ctr;
    logic                 is_jump;
  } btb_entry_t;

  localparam btb_entry_t ENTRY_RESET = '{
    valid:   1'b0,
    tag:     '0,
    target:  32'h0,
    ctr:     CTR_WEAK_NT,
    is_jump: 1'b0
  };

  function automatic logic is_ctrl_op(input op_type op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// -----------------------------------------------------------------------------
// sat_counter2
// Combinational next-state for a 2-bit saturating up/down counter.
//   i_ctr - current counter value
//   i_up  - 1: count up (saturate at 2'b11), 0: count down (saturate at 2'b00)
//   o_ctr - next counter value
// -----------------------------------------------------------------------------
module sat_counter2 (
  input  logic [1:0] i_ctr,
  input  logic       i_up,
  output logic [1:0] o_ctr
);

  // NOTE: assign a default first in every always_comb so no path leaves the
  // output unassigned; otherwise a latch is inferred.
  always_comb begin
    o_ctr = i_ctr;
    if (i_up) begin
      if (i_ctr != 2'b11) o_ctr = i_ctr + 2'd1;
    end else begin
      if (i_ctr != 2'b00) o_ctr = i_ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// -----------------------------------------------------------------------------
// branch_predictor
// Direct-mapped BTB with 2-bit saturating direction counters. Predicts the
// fetch PC's next address, checks resolved outcomes from EX, raises a
// redirect on mispredict and trains the table.
// Ports:
//   clk, rst_n                 - clock (rising edge), async active-low reset
//   if_valid, if_pc            - fetch lookup request
//   pred_taken, pred_target    - combinational prediction for if_pc
//   ex_valid, ex_optype,
//   ex_pc, ex_taken, ex_target - resolved instruction from EX
//   ex_pred_taken,
//   ex_pred_target             - prediction that travelled with it
//   mispredict, redirect_pc    - combinational flush request and correct PC
//   ctrl_count                 - resolved control-flow instructions (sat.)
//   mispredict_count           - mispredictions (sat.)
// -----------------------------------------------------------------------------
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = 30 - IDX_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        if_valid,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  op_type      ex_optype,
  input  logic [31:0] ex_pc,
  input  logic        ex_taken,
  input  logic [31:0] ex_target,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] ctrl_count,
  output logic [31:0] mispredict_count
);

  btb_entry_t r_table [ENTRIES];
  logic [31:0] r_ctrl_count;
  logic [31:0] r_mispredict_count;

  // ---------------------------------------------------------------- lookup
  logic [IDX_W-1:0]     w_if_idx;
  logic [TAG_MAX_W-1:0] w_if_tag;
  btb_entry_t           w_if_entry;
  logic                 w_if_hit;

  assign w_if_idx   = if_pc[IDX_W+1:2];
  assign w_if_tag   = TAG_MAX_W'(if_pc[31 -: TAG_W]);
  assign w_if_entry = r_table[w_if_idx];
  assign w_if_hit   = w_if_entry.valid && (w_if_entry.tag == w_if_tag);

  // Reads registered state only, so a same-cycle update to this index is not
  // visible until the following cycle.
  assign pred_taken  = if_valid && w_if_hit && (w_if_entry.is_jump || w_if_entry.ctr[1]);
  assign pred_target = pred_taken ? w_if_entry.target : if_pc + 32'd4;

  // ------------------------------------------------------------ EX checking
  logic [IDX_W-1:0]     w_ex_idx;
  logic [TAG_MAX_W-1:0] w_ex_tag;
  btb_entry_t           w_ex_entry;
  logic                 w_ex_hit;
  logic                 w_ex_ctrl;
  logic [31:0]          w_ex_pc4;

  assign w_ex_idx   = ex_pc[IDX_W+1:2];
  assign w_ex_tag   = TAG_MAX_W'(ex_pc[31 -: TAG_W]);
  assign w_ex_entry = r_table[w_ex_idx];
  assign w_ex_hit   = w_ex_entry.valid && (w_ex_entry.tag == w_ex_tag);
  assign w_ex_ctrl  = ex_valid && is_ctrl_op(ex_optype);
  assign w_ex_pc4   = ex_pc + 32'd4;

  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = w_ex_pc4;
    if (w_ex_ctrl) begin
      mispredict = (ex_taken != ex_pred_taken) ||
                   (ex_taken && (ex_target != ex_pred_target));
      if (ex_taken) redirect_pc = ex_target;
    end else if (ex_valid && ex_pred_taken) begin
      // A non-branch was predicted taken: the BTB entry is stale.
      mispredict = 1'b1;
    end
  end

  // ------------------------------------------------------------ table update
  logic [1:0] w_ctr_next;
  logic       w_wr_en;
  btb_entry_t w_wr_entry;

  sat_counter2 u_ctr (
    .i_ctr (w_ex_entry.ctr),
    .i_up  (ex_taken),
    .o_ctr (w_ctr_next)
  );

  always_comb begin
    w_wr_en    = 1'b0;
    w_wr_entry = w_ex_entry;
    if (w_ex_ctrl) begin
      if (w_ex_hit) begin
        w_wr_en            = 1'b1;
        w_wr_entry.ctr     = w_ctr_next;
        w_wr_entry.is_jump = (ex_optype != OP_BRANCH);
        if (ex_taken) w_wr_entry.target = ex_target;
      end else if (ex_taken) begin
        w_wr_en    = 1'b1;
        w_wr_entry = '{valid:   1'b1,
                       tag:     w_ex_tag,
                       target:  ex_target,
                       ctr:     CTR_WEAK_T,
                       is_jump: (ex_optype != OP_BRANCH)};
      end
    end else if (ex_valid && w_ex_hit) begin
      w_wr_en          = 1'b1;
      w_wr_entry.valid = 1'b0;
    end
  end

  // NOTE: this table must be reset (every entry invalid, counters weakly
  // not-taken), so it is built from flops rather than an inferred RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) r_table[i] <= ENTRY_RESET;
    end else if (w_wr_en) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      r_table[w_ex_idx] <= w_wr_entry;
    end
  end

  // ------------------------------------------------------------ statistics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ctrl_count       <= 32'h0;
      r_mispredict_count <= 32'h0;
    end else begin
      if (w_ex_ctrl && (r_ctrl_count != 32'hFFFF_FFFF))
        r_ctrl_count <= r_ctrl_count + 32'd1;
      if (mispredict && (r_mispredict_count != 32'hFFFF_FFFF))
        r_mispredict_count <= r_mispredict_count + 32'd1;
    end
  end

  assign ctrl_count       = r_ctrl_count;
  assign mispredict_count = r_mispredict_count;

  // Byte-offset bits of word-aligned PCs carry no information.
  logic w_unused;
  assign w_unused = ^{if_pc[1:0], ex_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor
// Directed scenarios plus a randomized run, checked against a behavioural BTB
// model (plain arrays of valid/tag/target/counter/jump indexed by pc/4 % 16).
// -----------------------------------------------------------------------------
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_valid;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  op_type      ex_optype;
  logic [31:0] ex_pc;
  logic        ex_taken;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc;
  logic [31:0] ctrl_count;
  logic [31:0] mispredict_count;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  branch_predictor #(.ENTRIES(16)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .if_valid         (if_valid),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .ex_valid         (ex_valid),
    .ex_optype        (ex_optype),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .mispredict       (mispredict),
    .redirect_pc      (redirect_pc),
    .ctrl_count       (ctrl_count),
    .mispredict_count (mispredict_count)
  );

  // ------------------------------------------------------------ reference model
  bit          m_valid [16];
  logic [31:0] m_tag   [16];
  logic [31:0] m_tgt   [16];
  int          m_ctr   [16];
  bit          m_jump  [16];
  longint      m_ctrl_cnt;
  longint      m_mis_cnt;

  function automatic int idx_of(input logic [31:0] pc);
    return int'((pc / 32'd4) % 32'd16);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] pc);
    return pc / 32'd64;
  endfunction

  function automatic bit m_is_ctrl(input op_type op);
    return op == OP_BRANCH || op == OP_JAL || op == OP_JALR;
  endfunction

  function automatic bit m_pred_taken(input bit v, input logic [31:0] pc);
    int i;
    i = idx_of(pc);
    return v && m_valid[i] && (m_tag[i] == tag_of(pc)) && (m_jump[i] || m_ctr[i] >= 2);
  endfunction

  function automatic logic [31:0] m_pred_target(input bit v, input logic [31:0] pc);
    return m_pred_taken(v, pc) ? m_tgt[idx_of(pc)] : pc + 32'd4;
  endfunction

  function automatic bit m_mis();
    if (!ex_valid) return 1'b0;
    if (m_is_ctrl(ex_optype))
      return (ex_taken != ex_pred_taken) || (ex_taken && ex_target != ex_pred_target);
    return ex_pred_taken;
  endfunction

  function automatic logic [31:0] m_redirect();
    return (ex_valid && m_is_ctrl(ex_optype) && ex_taken) ? ex_target : ex_pc + 32'd4;
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1; m_jump[i] = 1'b0;
    end
    m_ctrl_cnt = 0;
    m_mis_cnt  = 0;
  endtask

  // Applies the currently driven EX outcome to the model (one clock edge).
  task automatic m_update();
    int i;
    bit hit;
    if (!rst_n) return;
    i   = idx_of(ex_pc);
    hit = m_valid[i] && (m_tag[i] == tag_of(ex_pc));
    if (m_mis() && m_mis_cnt < 64'hFFFF_FFFF) m_mis_cnt++;
    if (ex_valid && m_is_ctrl(ex_optype)) begin
      if (m_ctrl_cnt < 64'hFFFF_FFFF) m_ctrl_cnt++;
      if (hit) begin
        m_ctr[i]  = ex_taken ? ((m_ctr[i] == 3) ? 3 : m_ctr[i] + 1)
                             : ((m_ctr[i] == 0) ? 0 : m_ctr[i] - 1);
        if (ex_taken) m_tgt[i] = ex_target;
        m_jump[i] = (ex_optype != OP_BRANCH);
      end else if (ex_taken) begin
        m_valid[i] = 1'b1; m_tag[i] = tag_of(ex_pc); m_tgt[i] = ex_target;
        m_ctr[i]   = 2;    m_jump[i] = (ex_optype != OP_BRANCH);
      end
    end else if (ex_valid && hit) begin
      m_valid[i] = 1'b0;
    end
  endtask

  // ------------------------------------------------------------ stimulus helpers
  task automatic tick();
    @(posedge clk);
    m_update();
    #1;
  endtask

  task automatic drive_ex(input bit v, input op_type op, input logic [31:0] pc,
                          input bit t, input logic [31:0] tg,
                          input bit pt, input logic [31:0] ptg);
    ex_valid = v; ex_optype = op; ex_pc = pc; ex_taken = t; ex_target = tg;
    ex_pred_taken = pt; ex_pred_target = ptg;
  endtask

  task automatic idle_ex();
    drive_ex(1'b0, OP_ALU, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  // ------------------------------------------------------------ scenarios
  task automatic test_reset();
    rst_n = 1'b0; if_valid = 1'b1; if_pc = 32'h100; idle_ex();
    m_reset();
    #23 rst_n = 1'b1;
    tick();
    n_tests++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL reset_pred_taken: got %b want 0", pred_taken); end
    n_tests++; if (pred_target !== 32'h104) begin n_fail++; $display("FAIL reset_pred_target: got %h want 00000104", pred_target); end
    n_tests++; if (ctrl_count !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl_count: got %0d want 0", ctrl_count); end
    n_tests++; if (mispredict_count !== 32'h0) begin n_fail++; $display("FAIL reset_mis_count: got %0d want 0", mispredict_count); end
  endtask

  task automatic test_alloc();
    drive_ex(1'b1, OP_BRANCH, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    #1;
    n_tests++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL alloc_mispredict: got %b want 1", mispredict); end
    n_tests++; if (redirect_pc !== 32'h80) begin n_fail++; $display("FAIL alloc_redirect: got %h want 00000080", redirect_pc); end
    tick();
    idle_ex(); if_valid = 1'b1; if_pc = 32'h100; #1;
    n_tests++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL alloc_pred_taken: got %b want 1", pred_taken); end
    n_tests++; if (pred_target !== 32'h80) begin n_fail++; $display("FAIL alloc_pred_target: got %h want 00000080", pred_target); end
    n_tests++; if (mispredict_count !== 32'd1) begin n_fail++; $display("FAIL alloc_mis_count: got %0d want 1", mispredict_count); end
    n_tests++; if (ctrl_count !== 32'd1) begin n_fail++; $display("FAIL alloc_ctrl_count: got %0d want 1", ctrl_count); end
  endtask

  // Counter walk from weak-taken: N,N,T,T,T,N -> 01,00,01,10,11,10.
  task automatic test_counter();
    bit outcome  [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    bit exp_pred [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    bit pre_pred;
    for (int k = 0; k < 6; k++) begin
      if_valid = 1'b1; if_pc = 32'h100;
      pre_pred = (k == 0) ? 1'b1 : exp_pred[k-1];
      drive_ex(1'b1, OP_BRANCH, 32'h100, outcome[k], 32'h80, pre_pred, pre_pred ? 32'h80 : 32'h104);
      #1;
      // Same-cycle lookup still sees the pre-update entry.
      n_tests++; if (pred_taken !== pre_pred) begin n_fail++; $display("FAIL ctr_same_cycle[%0d]: got %b want %b", k, pred_taken, pre_pred); end
      n_tests++; if (mispredict !== (outcome[k] != pre_pred)) begin n_fail++; $display("FAIL ctr_mispredict[%0d]: got %b want %b", k, mispredict, outcome[k] != pre_pred); end
      tick();
      idle_ex(); #1;
      n_tests++; if (pred_taken !== exp_pred[k]) begin n_fail++; $display("FAIL ctr_pred[%0d]: got %b want %b", k, pred_taken, exp_pred[k]); end
    end
  endtask

  task automatic test_jal();
    drive_ex(1'b1, OP_JAL, 32'h200, 1'b1, 32'h400, 1'b0, 32'h204);
    #1;
    n_tests++; if (redirect_pc !== 32'h400 || mispredict !== 1'b1) begin n_fail++; $display("FAIL jal_redirect: got %b/%h want 1/00000400", mispredict, redirect_pc); end
    tick();
    idle_ex(); if_valid = 1'b1; if_pc = 32'h200; #1;
    n_tests++; if (pred_taken !== 1'b1 || pred_target !== 32'h400) begin n_fail++; $display("FAIL jal_pred: got %b/%h want 1/00000400", pred_taken, pred_target); end
    // Correctly predicted resolution: no mispredict.
    drive_ex(1'b1, OP_JAL, 32'h200, 1'b1, 32'h400, 1'b1, 32'h400);
    #1;
    n_tests++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL jal_correct: got %b want 0", mispredict); end
    tick();
    idle_ex(); #1;
    n_tests++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL jal_still_taken: got %b want 1", pred_taken); end
  endtask

  task automatic test_alias();
    // 0x40 and 0x100 share index 0 with different tags.
    if_valid = 1'b1; if_pc = 32'h40; idle_ex(); #1;
    n_tests++; if (pred_taken !== 1'b0 || pred_target !== 32'h44) begin n_fail++; $display("FAIL alias_no_hit: got %b/%h want 0/00000044", pred_taken, pred_target); end
    drive_ex(1'b1, OP_BRANCH, 32'h40, 1'b1, 32'h300, 1'b0, 32'h44);
    tick();
    idle_ex(); if_pc = 32'h100; #1;
    n_tests++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL alias_evicted: got %b want 0", pred_taken); end
    if_pc = 32'h40; #1;
    n_tests++; if (pred_taken !== 1'b1 || pred_target !== 32'h300) begin n_fail++; $display("FAIL alias_new: got %b/%h want 1/00000300", pred_taken, pred_target); end
  endtask

  task automatic test_stale();
    drive_ex(1'b1, OP_ALU, 32'h200, 1'b0, 32'h0, 1'b1, 32'h400);
    #1;
    n_tests++; if (mispredict !== 1'b1) begin n_fail++; $display("FAIL stale_mispredict: got %b want 1", mispredict); end
    n_tests++; if (redirect_pc !== 32'h204) begin n_fail++; $display("FAIL stale_redirect: got %h want 00000204", redirect_pc); end
    tick();
    idle_ex(); if_valid = 1'b1; if_pc = 32'h200; #1;
    n_tests++; if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin n_fail++; $display("FAIL stale_invalidated: got %b/%h want 0/00000204", pred_taken, pred_target); end
    n_tests++; if (mispredict_count !== 32'(m_mis_cnt)) begin n_fail++; $display("FAIL stale_mis_count: got %0d want %0d", mispredict_count, m_mis_cnt); end
  endtask

  task automatic test_wrap();
    if_valid = 1'b1; if_pc = 32'hFFFF_FFFC; idle_ex(); #1;
    n_tests++; if (pred_target !== 32'h0) begin n_fail++; $display("FAIL wrap_pred_target: got %h want 00000000", pred_target); end
    drive_ex(1'b1, OP_LOAD, 32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h80); #1;
    n_tests++; if (redirect_pc !== 32'h0 || mispredict !== 1'b1) begin n_fail++; $display("FAIL wrap_redirect: got %b/%h want 1/00000000", mispredict, redirect_pc); end
    tick();
    idle_ex(); if_valid = 1'b0; if_pc = 32'h40; #1;
    n_tests++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL no_if_valid: got %b want 0", pred_taken); end
  endtask

  task automatic test_random();
    logic [31:0] pc_pool  [6] = '{32'h100, 32'h40, 32'h200, 32'h140, 32'hFFFF_FFFC, 32'h3C};
    logic [31:0] tgt_pool [4] = '{32'h80, 32'h300, 32'h400, 32'h1000};
    logic [31:0] pc;
    op_type      op;
    bit          t;
    for (int n = 0; n < 400; n++) begin
      pc = pc_pool[$urandom_range(0, 5)];
      op = op_type'($urandom_range(0, 7));
      t  = (op == OP_JAL || op == OP_JALR) ? 1'b1 : (op == OP_BRANCH) ? 1'($urandom_range(0, 1)) : 1'b0;
      if ($urandom_range(0, 9) < 7)
        drive_ex(1'($urandom_range(0, 3) != 0), op, pc, t, tgt_pool[$urandom_range(0, 3)],
                 m_pred_taken(1'b1, pc), m_pred_target(1'b1, pc));
      else
        drive_ex(1'($urandom_range(0, 3) != 0), op, pc, t, tgt_pool[$urandom_range(0, 3)],
                 1'($urandom_range(0, 1)), tgt_pool[$urandom_range(0, 3)]);
      if_valid = 1'($urandom_range(0, 7) != 0);
      if_pc    = pc_pool[$urandom_range(0, 5)];
      #1;
      n_tests++; if (pred_taken !== m_pred_taken(if_valid, if_pc) || pred_target !== m_pred_target(if_valid, if_pc)) begin
        n_fail++; $display("FAIL rnd_pred[%0d]: got %b/%h want %b/%h", n, pred_taken, pred_target,
                           m_pred_taken(if_valid, if_pc), m_pred_target(if_valid, if_pc));
      end
      n_tests++; if (mispredict !== m_mis()) begin n_fail++; $display("FAIL rnd_mispredict[%0d]: got %b want %b", n, mispredict, m_mis()); end
      if (m_mis()) begin
        n_tests++; if (redirect_pc !== m_redirect()) begin n_fail++; $display("FAIL rnd_redirect[%0d]: got %h want %h", n, redirect_pc, m_redirect()); end
      end
      tick();
    end
    idle_ex(); #1;
    n_tests++; if (ctrl_count !== 32'(m_ctrl_cnt)) begin n_fail++; $display("FAIL rnd_ctrl_count: got %0d want %0d", ctrl_count, m_ctrl_cnt); end
    n_tests++; if (mispredict_count !== 32'(m_mis_cnt)) begin n_fail++; $display("FAIL rnd_mis_count: got %0d want %0d", mispredict_count, m_mis_cnt); end
  endtask

  task automatic test_midreset();
    drive_ex(1'b1, OP_JAL, 32'h200, 1'b1, 32'h400, 1'b0, 32'h204);
    tick();
    idle_ex(); if_valid = 1'b1; if_pc = 32'h200; #1;
    n_tests++; if (pred_taken !== 1'b1) begin n_fail++; $display("FAIL mid_pre_pred: got %b want 1", pred_taken); end
    // Assert reset between edges, while an update is being presented.
    drive_ex(1'b1, OP_BRANCH, 32'h100, 1'b1, 32'h80, 1'b0, 32'h104);
    #2 rst_n = 1'b0; m_reset(); #1;
    n_tests++; if (pred_taken !== 1'b0 || pred_target !== 32'h204) begin n_fail++; $display("FAIL mid_pred: got %b/%h want 0/00000204", pred_taken, pred_target); end
    n_tests++; if (ctrl_count !== 32'h0 || mispredict_count !== 32'h0) begin n_fail++; $display("FAIL mid_counts: got %0d/%0d want 0/0", ctrl_count, mispredict_count); end
    n_tests++; if (mispredict !== 1'b1 || redirect_pc !== 32'h80) begin n_fail++; $display("FAIL mid_comb_mis: got %b/%h want 1/00000080", mispredict, redirect_pc); end
    tick();
    rst_n = 1'b1;
    // First edge after release performs the presented update.
    tick();
    idle_ex(); if_pc = 32'h100; #1;
    n_tests++; if (pred_taken !== 1'b1 || pred_target !== 32'h80) begin n_fail++; $display("FAIL post_reset_update: got %b/%h want 1/00000080", pred_taken, pred_target); end
    n_tests++; if (ctrl_count !== 32'd1 || mispredict_count !== 32'd1) begin n_fail++; $display("FAIL post_reset_counts: got %0d/%0d want 1/1", ctrl_count, mispredict_count); end
    if_pc = 32'h200; #1;
    n_tests++; if (pred_taken !== 1'b0) begin n_fail++; $display("FAIL post_reset_cleared: got %b want 0", pred_taken); end
  endtask

  initial begin
    test_reset();
    test_alloc();
    test_counter();
    test_jal();
    test_alias();
    test_stale();
    test_wrap();
    test_random();
    test_midreset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
